adjust_repeater: RTL and testbench
==================================

# adjust_repeater

Press-and-hold step generator for the clock's time-setting path. It sits directly downstream of the adjust delayer/debouncer and consumes its debounced, active-high `adjust_delayed` level. It emits a one-clock `step` pulse on each new press and, while the button stays held, auto-repeat pulses at a prescaled-tick rate. The time-set counters consume `step` as an increment enable.

## Interface
- `HOLD_TICKS`, default 50: ticks after the press step before auto-repeat starts; must be ≥ 1.
- `REPEAT_TICKS`, default 10: ticks between auto-repeat steps; must be ≥ 2.
- `ACCEL_STEPS`, default 8: repeat steps before the interval halves (used only with the macro).
- `CNT_W`, default 8: width of the tick counter; must hold `max(HOLD_TICKS, REPEAT_TICKS)`.

Ports:
- `clk`, in, 1: single clock; all logic updates on its rising edge.
- `clear_n`, in, 1: synchronous, active-low reset.
- `tick`, in, 1: one-`clk`-wide prescaled enable (nominally 100 Hz).
- `adjust_delayed`, in, 1: debounced adjust level; 1 = pressed.
- `step`, out, 1: registered one-`clk` increment pulse.
- `repeating`, out, 1: registered; 1 while in REPEAT.

## Operation
- The block registers `adjust_delayed` into `prev`. A press edge is `adjust_delayed & ~prev`.
- States:
  - IDLE: no step, counter held at 0.
  - HOLD: waiting out the hold delay.
  - REPEAT: auto-repeating.
- IDLE → HOLD on a press edge. Assert `step` on the next cycle and clear the counter.
- HOLD:
  - If `adjust_delayed` = 0, go to IDLE.
  - Else on `tick`, increment the counter.
  - When the counter is `HOLD_TICKS-1` and `tick` = 1: pulse `step`, clear the counter, go to REPEAT.
- REPEAT:
  - If `adjust_delayed` = 0, go to IDLE.
  - Else on `tick`, increment the counter.
  - When the counter is `interval-1` and `tick` = 1: pulse `step`, clear the counter, and increment the saturating repeat count.
- `interval` is `REPEAT_TICKS` unless acceleration applies (see Configuration).
- Release takes priority. If release and a qualifying `tick` fall in the same cycle, no `step` is produced and the next state is IDLE.
- A `tick` arriving in the press-edge cycle is not counted.
- The counter and the repeat count clear on every entry to IDLE.

## Timing
- Reset (`clear_n` = 0 at a clock edge), effective on the following cycle:
  - state = IDLE; counter = 0; repeat count = 0.
  - `step` = 0; `repeating` = 0.
  - `prev` = 1, so a button held through reset produces no step until it is released and pressed again.
- Reset mid-HOLD or mid-REPEAT aborts immediately; no `step` is emitted in the reset cycle.
- Press latency: `step` is high exactly 1 cycle after the first cycle `adjust_delayed` = 1.
- First repeat `step`: 1 cycle after the `HOLD_TICKS`-th `tick` following the press cycle. `repeating` rises in that same cycle.
- Subsequent steps: 1 cycle after every `interval`-th `tick`.
- `step` is never high on two consecutive cycles.
- `repeating` falls 1 cycle after `adjust_delayed` is sampled 0.

## Configuration
- Macro `ADJUST_REPEAT_ACCEL_EN`.
- Defined:
  - The repeat count (saturating at `ACCEL_STEPS`) selects the interval.
  - Once `ACCEL_STEPS` repeat steps have been emitted in the current hold, the interval becomes `REPEAT_TICKS/2`, floored, with a minimum of 1.
  - The change takes effect from the next interval.
- Undefined:
  - The interval is always `REPEAT_TICKS`.
  - No repeat-count register exists; `ACCEL_STEPS` is ignored.

## Test plan
Parameters for all scenarios: `HOLD_TICKS`=3, `REPEAT_TICKS`=4, `ACCEL_STEPS`=2, `tick` every 4th clk.
- Short press: `adjust_delayed` high for 5 clk, then low → exactly one `step`, 1 clk after the rise; `repeating` stays 0.
- Hold for 30 ticks, macro undefined → `step` at press+1. Next `step` 1 clk after the 3rd tick, then after every 4th tick: 1 + 1 + 6 = 8 steps total. `repeating` = 1 from the 2nd step until 1 clk after release.
- Same hold with `ADJUST_REPEAT_ACCEL_EN` → repeat spacing is 4 ticks for the first 2 repeats, then 2 ticks. Total `step` count = 1 + 1 + 2 + 9 = 13.
- Release in the same clk as the qualifying tick (3rd hold tick) → no `step` in that or the next cycle; state IDLE; `repeating` = 0.
- `clear_n` low for 1 clk during REPEAT with `adjust_delayed` still high → `step` = 0 and `repeating` = 0 the next cycle. No further steps until `adjust_delayed` goes 0 and then 1 again, which then gives `step` 1 clk after the rise.
- `tick` coincident with the press edge → first repeat still needs 3 further ticks (the coincident tick is not counted).

Source files
------------

// File: rtl/adjust_repeater.sv
// adjust_repeater: press-and-hold step generator for the time-setting path.
// Emits a one-clk `step` on each new press of the debounced adjust level and,
// while held, auto-repeat steps every REPEAT_TICKS prescaled ticks after an
// initial HOLD_TICKS delay.
// Optional feature macro: ADJUST_REPEAT_ACCEL_EN -- after ACCEL_STEPS repeat
// steps within one hold, the repeat interval drops to REPEAT_TICKS/2 (min 1).
module adjust_repeater #(
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned REPEAT_TICKS = 10,
  parameter int unsigned ACCEL_STEPS  = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic clear_n,
  input  logic tick,
  input  logic adjust_delayed,
  output logic step,
  output logic repeating
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_t;

  localparam int unsigned MAX_TICKS = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  // Elaboration-time parameter sanity check
  if (HOLD_TICKS < 1 || REPEAT_TICKS < 2 || ACCEL_STEPS < 1 ||
      (MAX_TICKS >> CNT_W) != 0) begin : g_param_err
    $error("adjust_repeater: illegal parameter combination");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] interval_last;
  logic             prev;
  logic             press;
  logic             step_nxt;
  logic             rpt_inc;

  assign press = adjust_delayed & ~prev;

`ifdef ADJUST_REPEAT_ACCEL_EN
  localparam int unsigned HALF_TICKS = (REPEAT_TICKS / 2 < 1) ? 1 : REPEAT_TICKS / 2;
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(HALF_TICKS - 1);
  localparam int unsigned RPT_W = $clog2(ACCEL_STEPS + 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(ACCEL_STEPS);

  logic [RPT_W-1:0] rpt_cnt;

  // Saturating count of repeat steps in the current hold; cleared on IDLE entry
  always_ff @(posedge clk) begin
    if (!clear_n || state_nxt == S_IDLE) begin
      rpt_cnt <= '0;
    end else if (rpt_inc && rpt_cnt != RPT_MAX) begin
      rpt_cnt <= rpt_cnt + RPT_W'(1);
    end
  end

  // Counter is cleared on every step, so a new interval applies from the next period
  assign interval_last = (rpt_cnt == RPT_MAX) ? FAST_LAST : REP_LAST;
`else
  assign interval_last = REP_LAST;
`endif

  // State, counter, edge-detect and output registers
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      prev      <= 1'b1;
      step      <= 1'b0;
      repeating <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      prev      <= adjust_delayed;
      step      <= step_nxt;
      repeating <= (state_nxt == S_REPEAT);
    end
  end

  // Next-state logic; release wins over a coincident qualifying tick
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step_nxt  = 1'b0;
    rpt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (press) begin
          state_nxt = S_HOLD;
          step_nxt  = 1'b1;
        end
      end
      S_HOLD: begin
        if (!adjust_delayed) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt == HOLD_LAST) begin
            state_nxt = S_REPEAT;
            step_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_REPEAT: begin
        if (!adjust_delayed) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (tick) begin
          if (cnt == interval_last) begin
            step_nxt = 1'b1;
            rpt_inc  = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_adjust_repeater.sv
// Testbench for adjust_repeater: table of press scenarios plus hand-written
// reset sequences, with a per-cycle expected-output scoreboard.
module tb_adjust_repeater;

  localparam int HOLD = 3;
  localparam int REP  = 4;
  localparam int ACC  = 2;
`ifdef ADJUST_REPEAT_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic tick = 1'b0;
  logic adjust_delayed = 1'b0;
  logic step;
  logic repeating;

  always #5 clk = ~clk;

  adjust_repeater #(
    .HOLD_TICKS  (HOLD),
    .REPEAT_TICKS(REP),
    .ACCEL_STEPS (ACC),
    .CNT_W       (8)
  ) dut (
    .clk           (clk),
    .clear_n       (clear_n),
    .tick          (tick),
    .adjust_delayed(adjust_delayed),
    .step          (step),
    .repeating     (repeating)
  );

  typedef struct {
    logic step;
    logic rep;
  } exp_t;

  typedef struct {
    int   hold_clks;
    int   tph;
    int   exp_steps;
    logic exp_rep;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state (counts ticks since press)
  logic m_prev = 1'b1;
  logic m_active = 1'b0;
  logic m_rep = 1'b0;
  int   m_tcnt = 0;
  int   m_rcnt = 0;
  int   m_target = HOLD;

  int   steps_seen = 0;
  logic rep_seen = 1'b0;
  logic last_step = 1'b0;
  int   cyc = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one clock of inputs, predict outputs, compare after the edge
  task automatic cycle(input logic clr, input logic adj, input logic tk);
    exp_t e;
    exp_t got;
    clear_n        = clr;
    adjust_delayed = adj;
    tick           = tk;
    e.step = 1'b0;
    if (!clr) begin
      m_active = 1'b0;
      m_rep    = 1'b0;
      m_prev   = 1'b1;
    end else begin
      if (adj && !m_prev) begin
        e.step   = 1'b1;
        m_active = 1'b1;
        m_rep    = 1'b0;
        m_tcnt   = 0;
        m_rcnt   = 0;
        m_target = HOLD;
      end else if (!adj) begin
        m_active = 1'b0;
        m_rep    = 1'b0;
      end else if (m_active && tk) begin
        m_tcnt++;
        if (m_tcnt == m_target) begin
          e.step = 1'b1;
          m_tcnt = 0;
          if (m_rep) m_rcnt++;
          m_rep    = 1'b1;
          m_target = (ACCEL && m_rcnt >= ACC) ? ((REP / 2 < 1) ? 1 : REP / 2) : REP;
        end
      end
      m_prev = adj;
    end
    e.rep = m_rep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = sb.pop_front();
    check("step", step, got.step);
    check("repeating", repeating, got.rep);
    check("step_not_consecutive", step & last_step, 1'b0);
    if (step) steps_seen++;
    if (repeating) rep_seen = 1'b1;
    last_step = step;
  endtask

  task automatic scenario(input vec_t v, input int idx);
    steps_seen = 0;
    rep_seen   = 1'b0;
    for (int i = -4; i < v.hold_clks + 6; i++) begin
      cycle(1'b1, (i >= 0 && i < v.hold_clks), (((i + 4) % 4) == v.tph));
    end
    check_int($sformatf("steps_total[%0d]", idx), steps_seen, v.exp_steps);
    check($sformatf("repeating_seen[%0d]", idx), rep_seen, v.exp_rep);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{hold_clks: 5,   tph: 1, exp_steps: 1,                  exp_rep: 1'b0}; // short press
    tbl[1] = '{hold_clks: 120, tph: 2, exp_steps: (ACCEL ? 13 : 8),   exp_rep: 1'b1}; // 30-tick hold
    tbl[2] = '{hold_clks: 9,   tph: 1, exp_steps: 1,                  exp_rep: 1'b0}; // release on 3rd tick
    tbl[3] = '{hold_clks: 13,  tph: 0, exp_steps: 2,                  exp_rep: 1'b1}; // tick on press edge
    tbl[4] = '{hold_clks: 1,   tph: 0, exp_steps: 1,                  exp_rep: 1'b0}; // one-cycle press
    tbl[5] = '{hold_clks: 48,  tph: 3, exp_steps: 4,                  exp_rep: 1'b1}; // 12-tick hold

    // reset state
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);

    // button held through reset: no step until released and pressed again
    steps_seen = 0;
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, (i % 4) == 0);
    check_int("held_through_reset_steps", steps_seen, 0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) scenario(tbl[k], k);

    // reset during REPEAT with button still held
    steps_seen = 0;
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, (i % 4) == 0);
    check("repeating_before_reset", repeating, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    check("step_after_reset", step, 1'b0);
    check("repeating_after_reset", repeating, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, (i % 4) == 1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    check("repress_step", step, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check_int("reset_seq_steps", steps_seen, 3);

    // reset mid-HOLD: no step in the reset cycle
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    check("hold_reset_step", step, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
